// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed restoring divider, one quotient bit per clock.
// Ports: clk, rst_n (async active-low); start/a/b launch a divide in IDLE;
// busy high while working; done pulses one cycle with quotient/remainder/div_by_zero valid.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, next;
  logic [WIDTH-1:0] mb, dq, rem, res_q, res_r;
  logic [WIDTH:0] trial;
  logic [CW-1:0] cnt;
  logic sign_q, sign_r, dz;
  // Partial remainder stays below |b| <= 2^(WIDTH-1), so its shifted value fits WIDTH bits;
  // trial[WIDTH] is the borrow that decides restore vs keep.
  assign trial = {rem, dq[WIDTH-1]} - {1'b0, mb};
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = start ? (b == '0 ? DONE : CALC) : IDLE;
      CALC: next = cnt == '0 ? FIX : CALC;
      FIX:  next = DONE;
      DONE: next = IDLE;
    endcase
  end
  // dq starts as |a| and shifts out dividend bits while shifting in quotient bits.
  // Divide-by-zero results are preloaded at accept; FIX overwrites them otherwise.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      mb <= '0;
      dq <= '0;
      rem <= '0;
      res_q <= '0;
      res_r <= '0;
      cnt <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dz <= 1'b0;
    end else
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
            sign_r <= a[WIDTH-1];
            mb <= b[WIDTH-1] ? -b : b;
            dq <= a[WIDTH-1] ? -a : a;
            rem <= '0;
            cnt <= CW'(WIDTH - 1);
            dz <= b == '0;
            res_q <= '1;
            res_r <= a;
            div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          rem <= trial[WIDTH] ? {rem[WIDTH-2:0], dq[WIDTH-1]} : trial[WIDTH-1:0];
          dq <= {dq[WIDTH-2:0], ~trial[WIDTH]};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          res_q <= sign_q ? -dq : dq;
          res_r <= sign_r ? -rem : rem;
        end
        DONE: begin
          done <= 1'b1;
          quotient <= res_q;
          remainder <= res_r;
          div_by_zero <= dz;
        end
      endcase
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider (WIDTH=32).
module tb_seq_divider;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic dz;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, n_done = 0;
  logic prev_done = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic signed [W-1:0] x, logic signed [W-1:0] y);
    exp_t e;
    if (y == 0) begin e.q = '1; e.r = x; e.dz = 1'b1; end
    else if (x == 32'sh80000000 && y == -1) begin e.q = x; e.r = '0; e.dz = 1'b0; end
    else begin e.q = x / y; e.r = x % y; e.dz = 1'b0; end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      n_done++;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got done=1 q=%0d, required no done", $signed(quotient));
      end else begin
        e = sb.pop_front();
        if (quotient !== e.q) begin
          n_fail++;
          $display("FAIL quotient: got %0d, required %0d", $signed(quotient), $signed(e.q));
        end
        n_chk++;
        if (remainder !== e.r) begin
          n_fail++;
          $display("FAIL remainder: got %0d, required %0d", $signed(remainder), $signed(e.r));
        end
        n_chk++;
        if (div_by_zero !== e.dz) begin
          n_fail++;
          $display("FAIL div_by_zero: got %b, required %b", div_by_zero, e.dz);
        end
      end
      n_chk++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_at_done: got %b, required 0", busy);
      end
      n_chk++;
      if (prev_done) begin
        n_fail++;
        $display("FAIL done_pulse_width: got done high two cycles, required one");
      end
    end
    prev_done = done;
  end

  task automatic run_div(input logic [W-1:0] x, input logic [W-1:0] y, input bit sync);
    int n, lat;
    if (sync) @(negedge clk);
    lat = (y == '0) ? 1 : W + 2;
    start = 1'b1; a = x; b = y;
    sb.push_back(model(x, y));
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) begin start = 1'b0; a = $urandom; b = $urandom; end
      n++;
      if (done) break;
    end
    n_chk++;
    if (n - 1 != lat) begin
      n_fail++;
      $display("FAIL latency %0d/%0d: got %0d edges, required %0d", $signed(x), $signed(y), n - 1, lat);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_chk++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b q=%h r=%h, required all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_signs;
    run_div(32'd7, 32'd2, 1);
    run_div(-32'sd7, 32'd2, 1);
    run_div(32'd7, -32'sd2, 1);
    run_div(-32'sd7, -32'sd2, 1);
  endtask

  task automatic test_boundaries;
    run_div(32'h7fffffff, 32'd1, 1);
    run_div(32'h80000000, 32'hffffffff, 1);
    run_div(32'd100000, -32'sd100000, 1);
    run_div(32'd0, 32'd5, 1);
    run_div(32'h80000000, 32'd1, 1);
    run_div(32'd3, 32'h80000000, 1);
  endtask

  task automatic test_div_zero;
    run_div(32'd5, 32'd0, 1);
    run_div(32'd9, 32'd3, 1);
    run_div(-32'sd12, 32'd0, 1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) run_div($urandom, $urandom_range(1, 50000), 1);
  endtask

  task automatic test_back_to_back;
    bit seen;
    @(negedge clk);
    start = 1'b1; a = 32'd100; b = 32'd7;
    sb.push_back(model(32'd100, 32'd7));
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; a = 32'd20; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL handshake_done: got no done in 100 cycles, required done");
    end
    run_div(32'd50, 32'd5, 0);
    run_div(-32'sd1000, 32'd7, 0);
  endtask

  task automatic test_reset_mid;
    int d0;
    @(negedge clk);
    start = 1'b1; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b done=%b dz=%b q=%h r=%h, required all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    d0 = n_done;
    repeat (40) @(negedge clk);
    #1;
    n_chk++;
    if (n_done != d0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL discarded_op: got %0d dones busy=%b, required 0 dones busy=0", n_done - d0, busy);
    end
    run_div(32'd9, 32'd4, 1);
  endtask

  initial begin
    test_reset;
    test_signs;
    test_boundaries;
    test_div_zero;
    test_random;
    test_back_to_back;
    test_reset_mid;
    repeat (3) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL pending_results: got %0d outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
